timer_counter_8bit_top: RTL and testbench

Single-clock 8-bit up/down timer/counter with an integrated 4-stage clock prescaler, programmed through a zero-wait-state APB slave port. It is a peripheral on the APB bus. It counts ticks derived from pclk/2, /4, /8 or /16, supports load from a data register, and raises sticky overflow/underflow flags. All logic runs on pclk; the divided clocks are used only as tick enables, never as clocks.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_counter_8bit_top_if.sv | 24 ++
 rtl/clk_prescaler.sv | 25 ++
 rtl/timer_counter_8bit_top.sv | 122 ++++++++++++
 tb/tb_timer_counter_8bit_top.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit timer/counter: register addresses,
// TCR/TSR bit positions and the default bus widths.
package timer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_TSR  = 3'b001;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TDR  = 3'b010;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TCR  = 3'b011;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TCNT = 3'b100;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // Bits 6, 3 and 2 of TCR are reserved and never stored.
  localparam logic [DATA_WIDTH-1:0] TCR_WMASK = 8'hB3;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

endpackage

// File: rtl/timer_counter_8bit_top_if.sv
// APB slave bus bundle for the timer/counter.
interface timer_counter_8bit_top_if;
  import timer_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/clk_prescaler.sv
// Free-running 4-bit prescaler; bit k is pclk divided by 2^(k+1).
// The outputs are used only as tick sources, never as clocks.
module clk_prescaler (
  input  logic       pclk,
  input  logic       preset,
  output logic [3:0] clk_div
);

  logic [3:0] pre_q;
  logic [3:0] pre_d;

  // Next prescaler value: wraps every 16 cycles.
  always_comb begin
    pre_d = pre_q + 4'd1;
  end

  // Prescaler state register.
  always_ff @(posedge pclk) begin
    if (preset) pre_q <= 4'd0;
    else        pre_q <= pre_d;
  end

  assign clk_div = pre_q;

endmodule

// File: rtl/timer_counter_8bit_top.sv
// 8-bit up/down timer/counter with prescaled tick and APB register access.
// Optional macro TIMER_SLVERR_EN enables the pslverr response; without it
// pslverr is tied low while bad accesses are still ignored.
module timer_counter_8bit_top
  import timer_pkg::*;
(
  input  logic                     pclk,
  input  logic                     preset,
  timer_counter_8bit_top_if.slave  apb,
  output logic                     TMR_OVF,
  output logic                     TMR_UDF
);

  logic [3:0]            clk_in;
  logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
  logic [DATA_WIDTH-1:0] tcr_q, tcr_d;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [1:0]            tsr_q, tsr_d;
  logic                  sel_q, sel_d;
  logic                  tick;
  logic                  access;
  logic                  wr_tsr, wr_tdr, wr_tcr;
  logic                  set_ovf, set_udf;

  clk_prescaler u_prescaler (
    .pclk    (pclk),
    .preset  (preset),
    .clk_div (clk_in)
  );

  // Write strobes: only the three writable registers accept data.
  always_comb begin
    access = apb.psel & apb.penable;
    wr_tsr = access & apb.pwrite & (apb.paddr == ADDR_TSR);
    wr_tdr = access & apb.pwrite & (apb.paddr == ADDR_TDR);
    wr_tcr = access & apb.pwrite & (apb.paddr == ADDR_TCR);
  end

  // Tick on the rising edge of the selected prescaler output.
  always_comb begin
    sel_d = clk_in[tcr_q[TCR_CKS_HI:TCR_CKS_LO]];
    tick  = sel_d & ~sel_q;
  end

  // Register updates, counter step and sticky flag logic (set beats clear).
  always_comb begin
    tdr_d   = tdr_q;
    tcr_d   = tcr_q;
    tsr_d   = tsr_q;
    tcnt_d  = tcnt_q;
    set_ovf = 1'b0;
    set_udf = 1'b0;

    if (wr_tdr) tdr_d = apb.pwdata;
    if (wr_tcr) tcr_d = apb.pwdata & TCR_WMASK;
    if (wr_tsr) tsr_d = tsr_q & apb.pwdata[1:0];

    if (tcr_q[TCR_LOAD]) begin
      tcnt_d = tdr_q;
    end else if (tcr_q[TCR_EN] && tick) begin
      if (tcr_q[TCR_DIR]) begin
        tcnt_d  = tcnt_q - 8'd1;
        set_udf = (tcnt_q == 8'h00);
      end else begin
        tcnt_d  = tcnt_q + 8'd1;
        set_ovf = (tcnt_q == 8'hFF);
      end
    end

    tsr_d[TSR_OVF] = tsr_d[TSR_OVF] | set_ovf;
    tsr_d[TSR_UDF] = tsr_d[TSR_UDF] | set_udf;
  end

  // Read mux: combinational while a read is selected, zero otherwise.
  always_comb begin
    apb.prdata = '0;
    if (apb.psel && !apb.pwrite) begin
      case (apb.paddr)
        ADDR_TSR:  apb.prdata = {6'b0, tsr_q};
        ADDR_TDR:  apb.prdata = tdr_q;
        ADDR_TCR:  apb.prdata = tcr_q;
        ADDR_TCNT: apb.prdata = tcnt_q;
        default:   apb.prdata = '0;
      endcase
    end
  end

`ifdef TIMER_SLVERR_EN
  logic addr_valid;

  // Error on unmapped addresses or writes to the read-only counter.
  always_comb begin
    addr_valid  = (apb.paddr == ADDR_TSR) || (apb.paddr == ADDR_TDR) ||
                  (apb.paddr == ADDR_TCR) || (apb.paddr == ADDR_TCNT);
    apb.pslverr = access & (~addr_valid | (apb.pwrite & (apb.paddr == ADDR_TCNT)));
  end
`else
  assign apb.pslverr = 1'b0;
`endif

  assign apb.pready = 1'b1;
  assign TMR_OVF    = tsr_q[TSR_OVF];
  assign TMR_UDF    = tsr_q[TSR_UDF];

  // State registers; reset clears everything.
  always_ff @(posedge pclk) begin
    if (preset) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tcnt_q <= '0;
      tsr_q  <= '0;
      sel_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tcnt_q <= tcnt_d;
      tsr_q  <= tsr_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: tb/tb_timer_counter_8bit_top.sv
// Self-checking bench for timer_counter_8bit_top (scoreboard queue of
// expected values, one task per scenario).
module tb_timer_counter_8bit_top;
  import timer_pkg::*;

  logic pclk = 1'b0;
  logic preset;
  logic TMR_OVF, TMR_UDF;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

`ifdef TIMER_SLVERR_EN
  localparam logic SLV_EXP = 1'b1;
`else
  localparam logic SLV_EXP = 1'b0;
`endif

  timer_counter_8bit_top_if apb();

  timer_counter_8bit_top dut (
    .pclk    (pclk),
    .preset  (preset),
    .apb     (apb.slave),
    .TMR_OVF (TMR_OVF),
    .TMR_UDF (TMR_UDF)
  );

  always #5 pclk = ~pclk;

  task automatic bus_idle();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = a;   apb.pwdata = d;
    @(posedge pclk); #1 apb.penable = 1'b1;
    @(posedge pclk); #1 bus_idle();
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
    @(posedge pclk); #1 apb.penable = 1'b1;
    #1 d = apb.prdata; err = apb.pslverr;
    @(posedge pclk); #1 bus_idle();
  endtask

  task automatic hold_tcnt_read();
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = ADDR_TCNT;
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    logic err;
    logic [2:0] addrs [4] = '{ADDR_TSR, ADDR_TDR, ADDR_TCR, ADDR_TCNT};
    bus_idle();
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    checks++; if (apb.prdata !== 8'h00) begin errors++; $display("FAIL rst_prdata: got %h want 00", apb.prdata); end
    checks++; if (apb.pready !== 1'b1) begin errors++; $display("FAIL rst_pready: got %b want 1", apb.pready); end
    checks++; if (apb.pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b want 0", apb.pslverr); end
    checks++; if ({TMR_OVF, TMR_UDF} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b%b want 00", TMR_OVF, TMR_UDF); end
    preset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge pclk); #1;
      checks++;
      if (dut.clk_in !== 4'(n)) begin errors++; $display("FAIL rst_prescaler: got %h want %h", dut.clk_in, 4'(n)); end
    end
    foreach (addrs[i]) begin
      exp_q.push_back(8'h00);
      apb_read(addrs[i], d, err);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL rst_reg%0d: got %h want %h", addrs[i], d, e); end
    end
  endtask

  task automatic test_regs();
    logic [7:0] d, e;
    logic err;
    logic [2:0] wa [4] = '{ADDR_TDR, ADDR_TCR, ADDR_TCR, ADDR_TCR};
    logic [7:0] wd [4] = '{8'hA5, 8'h4C, 8'h23, 8'h00};
    logic [7:0] rd [4] = '{8'hA5, 8'h00, 8'h23, 8'h00};
    for (int i = 0; i < 4; i++) begin
      apb_write(wa[i], wd[i]);
      exp_q.push_back(rd[i]);
      apb_read(wa[i], d, err);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL reg_rw%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_up_ovf();
    logic [7:0] v, last, e, d, x;
    logic err;
    int since, nchg;
    apb_write(ADDR_TDR, 8'hF0);
    apb_write(ADDR_TCR, 8'h80);
    apb_write(ADDR_TCR, 8'h10);
    x = 8'hF0;
    for (int i = 0; i < 16; i++) begin x = x + 8'd1; exp_q.push_back(x); end
    hold_tcnt_read();
    #1 v = apb.prdata;
    checks++; if (v !== 8'hF0) begin errors++; $display("FAIL up_start: got %h want f0", v); end
    last = v; since = 0; nchg = 0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(posedge pclk); #1;
      since++;
      v = apb.prdata;
      if (v !== last) begin
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL up_value: got %h want %h", v, e); end
        if (nchg > 0) begin
          checks++; if (since != 2) begin errors++; $display("FAIL up_period: got %0d want 2", since); end
        end
        if (e == 8'hFF) begin
          checks++; if (TMR_OVF !== 1'b0) begin errors++; $display("FAIL up_ovf_early: got %b want 0", TMR_OVF); end
        end
        nchg++; since = 0; last = v;
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL up_timeout: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
    @(posedge pclk); #1;
    checks++; if (TMR_OVF !== 1'b1) begin errors++; $display("FAIL up_ovf_set: got %b want 1", TMR_OVF); end
    checks++; if (TMR_UDF !== 1'b0) begin errors++; $display("FAIL up_udf_quiet: got %b want 0", TMR_UDF); end
    bus_idle();
    apb_write(ADDR_TCR, 8'h00);
    exp_q.push_back(8'h01);
    apb_read(ADDR_TSR, d, err);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL up_tsr_read: got %h want %h", d, e); end
    apb_write(ADDR_TSR, 8'h03);
    checks++; if (TMR_OVF !== 1'b1) begin errors++; $display("FAIL tsr_w1_noeffect: got %b want 1", TMR_OVF); end
    apb_write(ADDR_TSR, 8'h02);
    checks++; if (TMR_OVF !== 1'b0) begin errors++; $display("FAIL tsr_w0_clear: got %b want 0", TMR_OVF); end
  endtask

  task automatic test_down_udf();
    logic [7:0] v, last, e;
    logic [7:0] seq [4] = '{8'h02, 8'h01, 8'h00, 8'hFF};
    apb_write(ADDR_TDR, 8'h03);
    apb_write(ADDR_TCR, 8'h80);
    apb_write(ADDR_TCR, 8'h30);
    foreach (seq[i]) exp_q.push_back(seq[i]);
    hold_tcnt_read();
    #1 v = apb.prdata;
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL dn_start: got %h want 03", v); end
    last = v;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(posedge pclk); #1;
      v = apb.prdata;
      if (v !== last) begin
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL dn_value: got %h want %h", v, e); end
        if (e == 8'h00) begin
          checks++; if (TMR_UDF !== 1'b0) begin errors++; $display("FAIL dn_udf_early: got %b want 0", TMR_UDF); end
        end
        last = v;
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL dn_timeout: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
    @(posedge pclk); #1;
    checks++; if (TMR_UDF !== 1'b1) begin errors++; $display("FAIL dn_udf_set: got %b want 1", TMR_UDF); end
    checks++; if (TMR_OVF !== 1'b0) begin errors++; $display("FAIL dn_ovf_quiet: got %b want 0", TMR_OVF); end
    bus_idle();
    apb_write(ADDR_TCR, 8'h00);
    apb_write(ADDR_TSR, 8'h00);
    checks++; if (TMR_UDF !== 1'b0) begin errors++; $display("FAIL dn_udf_clear: got %b want 0", TMR_UDF); end
  endtask

  task automatic test_pause();
    logic [7:0] v, last, h, e;
    int nchg;
    apb_write(ADDR_TDR, 8'h10);
    apb_write(ADDR_TCR, 8'h80);
    apb_write(ADDR_TCR, 8'h10);
    hold_tcnt_read();
    #1 last = apb.prdata;
    nchg = 0;
    for (int c = 0; c < 20 && nchg < 3; c++) begin
      @(posedge pclk); #1;
      v = apb.prdata;
      if (v !== last) begin nchg++; last = v; end
    end
    checks++; if (nchg != 3) begin errors++; $display("FAIL pause_run: got %0d steps want 3", nchg); end
    apb_write(ADDR_TCR, 8'h00);
    hold_tcnt_read();
    #1 h = apb.prdata;
    for (int c = 0; c < 20; c++) begin
      @(posedge pclk); #1;
      checks++; if (apb.prdata !== h) begin errors++; $display("FAIL pause_frozen: got %h want %h", apb.prdata, h); end
    end
    apb_write(ADDR_TCR, 8'h10);
    exp_q.push_back(h + 8'd1);
    hold_tcnt_read();
    #1 v = apb.prdata;
    checks++; if (v !== h) begin errors++; $display("FAIL pause_resume_hold: got %h want %h", v, h); end
    for (int c = 0; c < 6 && v === h; c++) begin
      @(posedge pclk); #1;
      v = apb.prdata;
    end
    e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL pause_resume: got %h want %h", v, e); end
    checks++; if ({TMR_OVF, TMR_UDF} !== 2'b00) begin errors++; $display("FAIL pause_flags: got %b%b want 00", TMR_OVF, TMR_UDF); end
    bus_idle();
    apb_write(ADDR_TCR, 8'h00);
  endtask

  task automatic test_cks3();
    logic [7:0] v, last, e, x;
    int since, nchg;
    apb_write(ADDR_TDR, 8'h00);
    apb_write(ADDR_TCR, 8'h83);
    apb_write(ADDR_TCR, 8'h13);
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin x = x + 8'd1; exp_q.push_back(x); end
    hold_tcnt_read();
    #1 v = apb.prdata;
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL cks3_start: got %h want 00", v); end
    last = v; since = 0; nchg = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge pclk); #1;
      since++;
      v = apb.prdata;
      if (v !== last) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL cks3_extra: got %h want no step", v);
        end else begin
          e = exp_q.pop_front();
          checks++; if (v !== e) begin errors++; $display("FAIL cks3_value: got %h want %h", v, e); end
        end
        if (nchg > 0) begin
          checks++; if (since != 16) begin errors++; $display("FAIL cks3_period: got %0d want 16", since); end
        end
        nchg++; since = 0; last = v;
      end
    end
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL cks3_256: got %h want 10", v); end
    exp_q.delete();
    bus_idle();
    apb_write(ADDR_TCR, 8'h00);
  endtask

  task automatic test_slverr();
    logic [7:0] d, e;
    logic err;
    apb_write(ADDR_TDR, 8'h3C);
    apb_write(ADDR_TCR, 8'h80);
    apb_write(ADDR_TCR, 8'h00);
    // Unmapped read: setup phase then access phase.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 3'b111;
    #1;
    checks++; if (apb.pslverr !== 1'b0) begin errors++; $display("FAIL err_setup_phase: got %b want 0", apb.pslverr); end
    @(posedge pclk); #1 apb.penable = 1'b1;
    #1;
    checks++; if (apb.pslverr !== SLV_EXP) begin errors++; $display("FAIL err_bad_read: got %b want %b", apb.pslverr, SLV_EXP); end
    checks++; if (apb.prdata !== 8'h00) begin errors++; $display("FAIL err_bad_rdata: got %h want 00", apb.prdata); end
    @(posedge pclk); #1 bus_idle();
    // Write to read-only TCNT.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = ADDR_TCNT; apb.pwdata = 8'h55;
    @(posedge pclk); #1 apb.penable = 1'b1;
    #1;
    checks++; if (apb.pslverr !== SLV_EXP) begin errors++; $display("FAIL err_tcnt_write: got %b want %b", apb.pslverr, SLV_EXP); end
    @(posedge pclk); #1 bus_idle();
    apb_write(3'b000, 8'hFF);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    apb_read(ADDR_TCNT, d, err);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL err_tcnt_kept: got %h want %h", d, e); end
    apb_read(ADDR_TDR, d, err);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL err_tdr_kept: got %h want %h", d, e); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_good_read: got %b want 0", err); end
  endtask

  task automatic test_reset_midcount();
    logic [7:0] d, e;
    logic err;
    apb_write(ADDR_TDR, 8'hFE);
    apb_write(ADDR_TCR, 8'h80);
    apb_write(ADDR_TCR, 8'h10);
    repeat (12) @(posedge pclk);
    #1;
    checks++; if (TMR_OVF !== 1'b1) begin errors++; $display("FAIL mid_ovf_before: got %b want 1", TMR_OVF); end
    preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0;
    checks++; if (TMR_OVF !== 1'b0) begin errors++; $display("FAIL mid_ovf_reset: got %b want 0", TMR_OVF); end
    repeat (4) @(posedge pclk);
    #1;
    exp_q.push_back(8'h00);
    apb_read(ADDR_TCNT, d, err);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL mid_tcnt_reset: got %h want %h", d, e); end
  endtask

  initial begin
    bus_idle();
    preset = 1'b1;
    @(posedge pclk); #1;
    test_reset();
    test_regs();
    test_up_ovf();
    test_down_udf();
    test_pause();
    test_cks3();
    test_slverr();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
